r2mdc_commutator_ctrl: RTL and testbench
========================================

Name: r2mdc_commutator_ctrl

Overview:
Inter-stage delay-commutator controller for the R2MDC FFT pipeline. It sits between two radix-2 butterfly stages. It takes the two complex output lanes of the upstream butterfly (upper Y0, lower Y1) and buffers and swaps them with D-deep delay lines and a counter-driven commutator. The result is complex pairs spaced D samples apart for the downstream butterfly, plus the matching twiddle index.

Parameters:
N, 16, FFT length in points; power of two, >= 4.
D, 4, commutator span in valid beats; power of two, 1 <= D <= N/4.
W, 16, width of each real/imag component; signed Q7.8 at W=16.

Ports:
clk  in  1  rising-edge clock.
rst_n  in  1  asynchronous active-low reset.
clear  in  1  synchronous restart: zeroes counters and the valid pipeline; delay-line data is left untouched.
in_valid  in  1  one beat of upstream pair present this cycle; no backpressure.
in_u_re, in_u_im  in  W each  upper lane (upstream Y0), signed.
in_l_re, in_l_im  in  W each  lower lane (upstream Y1), signed.
out_valid  out  1  downstream pair valid; registered.
out_sof  out  1  first valid pair of an output frame (N/2 pairs); registered.
out_a_re, out_a_im  out  W each  downstream butterfly A input.
out_b_re, out_b_im  out  W each  downstream butterfly B input.
tw_idx  out  log2(N/2)  twiddle exponent k for W_N^k applied downstream.

Behaviour:
- Reset (rst_n=0, async): all outputs 0; beat counter, fill counter and both delay lines 0.
- All state advances only on cycles with in_valid=1. Idle cycles hold all state, and out_valid=0 on them.
- Beat counter t counts mod N/2 and wraps continuously across frames.
- Commutator select: sel = bit log2(D) of t (0 = straight, 1 = cross).
- Lower delay line: DL delays in_l by D beats, giving l(t) = in_l(t-D).
- Straight: top = in_u, bottom = l. Cross: top = l, bottom = in_u.
- Upper delay line: DU delays top by D beats.
- Output pair for beat t: A = top(t-D), B = bottom(t). Both are registered, so out_* update one clock after the in_valid beat.
- Fill: the first D beats after reset or clear give out_valid=0. Every later in_valid beat gives out_valid=1 on the next clock, with no gaps across frame boundaries.
- Resulting order within a frame, for k in [0,D):
  - first pairs (Y0[k], Y0[k+D]);
  - then pairs (Y1[k], Y1[k+D]);
  - repeated per 2D-beat group.
- tw_idx = (j mod D) * (N/(2D)), where j is the output pair counter. j counts mod N/2 and is reset to 0 at the first valid output.
- out_sof = 1 exactly when out_valid=1 and j=0.
- Arithmetic: pure data movement. No add, scale or saturate; bit-exact pass-through of W-bit values.
- clear and in_valid in the same cycle: clear wins and the beat is dropped. On the next clock out_valid=0 and out_sof=0.
- Mid-stream clear: the next D beats refill before out_valid returns. Stale delay-line data never appears with out_valid=1, because the fill counter gates it.
- rst_n asserted mid-frame: immediate return to the reset state; no partial pair is emitted after release.
- D=N/4: one 2D group per frame. D=1: sel toggles every beat.

Test Plan:
1. N=16, D=4. After reset, stream in_u_re=0..7 and in_l_re=100..107, imag=0, 8 consecutive beats. Required: out_valid low for beats 0-3; pairs (A,B)_re = (0,4),(1,5),(2,6),(3,7) with tw_idx = 0,2,4,6 and out_sof on the first.
2. Continue a second frame with in_u_re=8..15, in_l_re=108..115. Required: pairs (100,104),(101,105),(102,106),(103,107), then (8,12)...(11,15); out_sof on the (8,12) pair; no out_valid gaps.
3. Same stream with in_valid deasserted on alternate cycles. Required: identical pair sequence, out_valid only one cycle after each valid beat, all outputs held in between.
4. Assert clear together with in_valid at beat 5 of a frame. Required: that beat dropped; next 4 valid beats give out_valid=0; the 5th gives out_sof=1, tw_idx=0.
5. Pulse rst_n low for a partial cycle mid-stream. Required: all outputs 0 immediately (asynchronously); after release, refill exactly as in test 1.
6. N=16, D=1, in_u_re=0..7, in_l_re=100..107. Required: first pair after 1 fill beat is (0,1) then (100,101), (2,3)... with tw_idx = 0 throughout. Also check sign preservation with -32768 and 32767 inputs.

Source files
------------

// File: rtl/r2mdc_commutator_ctrl.sv
// r2mdc_commutator_ctrl
//   Delay-commutator between two radix-2 butterfly stages of an R2MDC FFT.
//   The upstream butterfly gives an upper lane (Y0) and a lower lane (Y1).
//   The lower lane is delayed by D beats. A commutator then swaps or passes
//   the two lanes, and its top output is delayed by a further D beats. The
//   result is pairs spaced D samples apart for the next butterfly, together
//   with the twiddle exponent that the next butterfly applies.
//
// Ports
//   clk, rst_n             clock, asynchronous active-low reset
//   clear                  synchronous restart of counters and valid pipeline
//   in_valid               one upstream pair this cycle (no backpressure)
//   in_u_re/im, in_l_re/im upper / lower lane, signed W-bit
//   out_valid, out_sof     registered pair strobe, first pair of a frame
//   out_a_re/im, out_b_re/im  downstream butterfly A / B inputs
//   tw_idx                 twiddle exponent k for W_N^k
module r2mdc_commutator_ctrl #(
   parameter int N = 16,
   parameter int D = 4,
   parameter int W = 16
) (
   input  logic                          clk,
   input  logic                          rst_n,
   input  logic                          clear,
   input  logic                          in_valid,
   input  logic signed [W-1:0]           in_u_re,
   input  logic signed [W-1:0]           in_u_im,
   input  logic signed [W-1:0]           in_l_re,
   input  logic signed [W-1:0]           in_l_im,
   output logic                          out_valid,
   output logic                          out_sof,
   output logic signed [W-1:0]           out_a_re,
   output logic signed [W-1:0]           out_a_im,
   output logic signed [W-1:0]           out_b_re,
   output logic signed [W-1:0]           out_b_im,
   output logic [$clog2(N/2)-1:0]        tw_idx
);

   localparam int TW = $clog2(N/2);
   localparam int LD = $clog2(D);
   localparam int SH = $clog2(N/(2*D));
   localparam int FW = $clog2(D+1);

   logic [TW-1:0]    t_cnt;
   logic [TW-1:0]    j_cnt;
   logic [FW-1:0]    fill_cnt;
   logic [2*W-1:0]   dl [D];
   logic [2*W-1:0]   du [D];
   logic [2*W-1:0]   out_a;
   logic [2*W-1:0]   out_b;

   logic             adv;
   logic             sel;
   logic             fill_done;
   logic [2*W-1:0]   u_cur;
   logic [2*W-1:0]   l_cur;
   logic [2*W-1:0]   top;
   logic [2*W-1:0]   bottom;
   logic [TW-1:0]    tw_next;

   assign adv       = in_valid & ~clear;
   assign sel       = t_cnt[LD];
   assign u_cur     = {in_u_re, in_u_im};
   assign l_cur     = dl[D-1];
   assign top       = sel ? l_cur : u_cur;
   assign bottom    = sel ? u_cur : l_cur;
   assign fill_done = (fill_cnt == FW'(D));
   // (j mod D) * N/(2D); both factors are powers of two, so mask and shift.
   assign tw_next   = (j_cnt & TW'(D-1)) << SH;

   assign out_a_re = out_a[2*W-1:W];
   assign out_a_im = out_a[W-1:0];
   assign out_b_re = out_b[2*W-1:W];
   assign out_b_im = out_b[W-1:0];

   // Delay lines keep their contents across clear; the fill counter keeps
   // stale entries from ever being presented as valid.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < D; i++) begin
            dl[i] <= '0;
            du[i] <= '0;
         end
      end else if (adv) begin
         for (int i = 1; i < D; i++) begin
            dl[i] <= dl[i-1];
            du[i] <= du[i-1];
         end
         dl[0] <= {in_l_re, in_l_im};
         du[0] <= top;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         t_cnt     <= '0;
         j_cnt     <= '0;
         fill_cnt  <= '0;
         out_valid <= 1'b0;
         out_sof   <= 1'b0;
         out_a     <= '0;
         out_b     <= '0;
         tw_idx    <= '0;
      end else if (clear) begin
         t_cnt     <= '0;
         j_cnt     <= '0;
         fill_cnt  <= '0;
         out_valid <= 1'b0;
         out_sof   <= 1'b0;
      end else if (in_valid) begin
         t_cnt     <= t_cnt + TW'(1);
         out_valid <= fill_done;
         if (!fill_done) begin
            fill_cnt <= fill_cnt + FW'(1);
            out_sof  <= 1'b0;
         end else begin
            out_a   <= du[D-1];
            out_b   <= bottom;
            tw_idx  <= tw_next;
            out_sof <= (j_cnt == '0);
            j_cnt   <= j_cnt + TW'(1);
         end
      end else begin
         out_valid <= 1'b0;
         out_sof   <= 1'b0;
      end
   end

endmodule

// File: tb/tb_r2mdc_commutator_ctrl.sv
// Bench for r2mdc_commutator_ctrl: a D=4 and a D=1 instance share one input
// stream. The reference keeps every beat accepted since the last restart and
// derives each output pair from the frame ordering (Y0[k],Y0[k+D]) then
// (Y1[k],Y1[k+D]) per 2D group, delayed by the D-beat fill.
module tb_r2mdc_commutator_ctrl;

   localparam int N = 16;
   localparam int W = 16;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          clear = 1'b0;
   logic          in_valid = 1'b0;
   logic [W-1:0]  in_u_re = '0, in_u_im = '0, in_l_re = '0, in_l_im = '0;

   logic          v4, s4, v1, s1;
   logic [W-1:0]  a4re, a4im, b4re, b4im, a1re, a1im, b1re, b1im;
   logic [2:0]    tw4, tw1;

   r2mdc_commutator_ctrl #(.N(N), .D(4), .W(W)) dut4 (
      .clk(clk), .rst_n(rst_n), .clear(clear), .in_valid(in_valid),
      .in_u_re(in_u_re), .in_u_im(in_u_im), .in_l_re(in_l_re), .in_l_im(in_l_im),
      .out_valid(v4), .out_sof(s4),
      .out_a_re(a4re), .out_a_im(a4im), .out_b_re(b4re), .out_b_im(b4im),
      .tw_idx(tw4));

   r2mdc_commutator_ctrl #(.N(N), .D(1), .W(W)) dut1 (
      .clk(clk), .rst_n(rst_n), .clear(clear), .in_valid(in_valid),
      .in_u_re(in_u_re), .in_u_im(in_u_im), .in_l_re(in_l_re), .in_l_im(in_l_im),
      .out_valid(v1), .out_sof(s1),
      .out_a_re(a1re), .out_a_im(a1im), .out_b_re(b1re), .out_b_im(b1im),
      .tw_idx(tw1));

   always #5 clk = ~clk;

   int errors = 0;
   int checks = 0;

   logic [31:0] hu[$];
   logic [31:0] hl[$];
   logic [31:0] ea [2];
   logic [31:0] eb [2];
   int          etw [2];

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      hu.delete();
      hl.delete();
      for (int k = 0; k < 2; k++) begin
         ea[k] = '0; eb[k] = '0; etw[k] = 0;
      end
   endtask

   task automatic check_dut(input int k, input bit acc);
      int d, n, m, r, base;
      bit ev, es;
      logic        ov, os;
      logic [31:0] oa, ob;
      logic [2:0]  otw;
      d  = (k == 0) ? 4 : 1;
      n  = hu.size() - 1;
      ev = acc && (n >= d);
      es = 1'b0;
      if (ev) begin
         m    = n - d;
         r    = m % (2*d);
         base = m - r;
         if (r < d) begin
            ea[k] = hu[base+r];
            eb[k] = hu[base+r+d];
         end else begin
            ea[k] = hl[base+r-d];
            eb[k] = hl[base+r];
         end
         etw[k] = (m % d) * (N/(2*d));
         es     = ((m % (N/2)) == 0);
      end
      if (k == 0) begin
         ov = v4; os = s4; oa = {a4re, a4im}; ob = {b4re, b4im}; otw = tw4;
      end else begin
         ov = v1; os = s1; oa = {a1re, a1im}; ob = {b1re, b1im}; otw = tw1;
      end
      chk($sformatf("d%0d valid", d), 64'(ov), 64'(ev));
      chk($sformatf("d%0d sof", d), 64'(os), 64'(es));
      chk($sformatf("d%0d a", d), 64'(oa), 64'(ea[k]));
      chk($sformatf("d%0d b", d), 64'(ob), 64'(eb[k]));
      chk($sformatf("d%0d tw", d), 64'(otw), 64'(etw[k]));
   endtask

   task automatic beat(input bit v, input bit c, input logic [W-1:0] ur, input logic [W-1:0] ui,
                       input logic [W-1:0] lr, input logic [W-1:0] li);
      in_valid = v; clear = c;
      in_u_re = ur; in_u_im = ui; in_l_re = lr; in_l_im = li;
      @(posedge clk);
      #1;
      in_valid = 1'b0; clear = 1'b0;
      if (c) begin
         hu.delete();
         hl.delete();
      end else if (v) begin
         hu.push_back({ur, ui});
         hl.push_back({lr, li});
      end
      check_dut(0, v && !c);
      check_dut(1, v && !c);
   endtask

   task automatic async_reset_pulse();
      #2;
      rst_n = 1'b0;
      #1;
      chk("rst d4 outs", {v4, s4, a4re, a4im, b4re, b4im, tw4}, '0);
      chk("rst d1 outs", {v1, s1, a1re, a1im, b1re, b1im, tw1}, '0);
      rst_n = 1'b1;
      model_reset();
   endtask

   task automatic rnd_beat(input bit v, input bit c);
      beat(v, c, W'($urandom), W'($urandom), W'($urandom), W'($urandom));
   endtask

   initial begin
      model_reset();
      #3;
      chk("por d4 outs", {v4, s4, a4re, a4im, b4re, b4im, tw4}, '0);
      chk("por d1 outs", {v1, s1, a1re, a1im, b1re, b1im, tw1}, '0);
      @(posedge clk);
      #1;
      rst_n = 1'b1;

      // two back-to-back frames of ramp data
      for (int i = 0; i < 16; i++) beat(1'b1, 1'b0, W'(i), '0, W'(100+i), '0);
      // same ramp with alternate idle cycles
      for (int i = 0; i < 16; i++) begin
         beat(1'b1, 1'b0, W'(i), '0, W'(100+i), '0);
         beat(1'b0, 1'b0, '0, '0, '0, '0);
      end
      // clear coinciding with a valid beat, then refill
      for (int i = 0; i < 5; i++) beat(1'b1, 1'b0, W'(20+i), W'(i), W'(200+i), W'(i));
      beat(1'b1, 1'b1, 16'h0bad, 16'h0bad, 16'h0bad, 16'h0bad);
      for (int i = 0; i < 12; i++) beat(1'b1, 1'b0, W'(i), '0, W'(100+i), '0);
      // asynchronous reset mid-stream, then refill
      for (int i = 0; i < 3; i++) beat(1'b1, 1'b0, W'(40+i), '0, W'(140+i), '0);
      async_reset_pulse();
      for (int i = 0; i < 12; i++) beat(1'b1, 1'b0, W'(i), '0, W'(100+i), '0);
      // extremes: sign must pass through unchanged
      for (int i = 0; i < 16; i++)
         beat(1'b1, 1'b0, (i % 2) ? 16'h8000 : 16'h7fff, (i % 2) ? 16'h7fff : 16'h8000,
              (i % 3 == 0) ? 16'h8000 : 16'hffff, (i % 3 == 0) ? 16'h7fff : 16'h8001);
      // random traffic with sparse clears and resets
      for (int i = 0; i < 600; i++) begin
         if ($urandom_range(0, 199) == 0) async_reset_pulse();
         rnd_beat($urandom_range(0, 3) != 0, $urandom_range(0, 59) == 0);
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
